// File: rtl/io_port.sv
// rtl/io_port.sv - memory-mapped I/O responder: 4-entry transmit FIFO plus optional down-counter timer
// Optional timer is built only when IO_PORT_TIMER_EN is defined.
module io_port #(
  parameter logic [15:0] BASE = 16'hFFF0
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] Address,
  input  logic        WE,
  input  logic [7:0]  DataIn,
  output logic [7:0]  DataOut,
  output logic        SEL,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  logic [1:0] off;
  logic       wr;
  logic [7:0] mem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] cnt;
  logic       ovf;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push_req;
  logic       push;
  logic       exp_flag;
  logic [7:0] rdata;

  assign SEL      = (Address[15:2] == BASE[15:2]);
  assign off      = Address[1:0];
  assign wr       = WE && SEL;
  assign empty    = (cnt == 3'd0);
  assign full     = (cnt == 3'd4);
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : mem[rp];
  assign pop      = tx_valid && tx_ready;
  assign push_req = wr && (off == 2'd0);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= DataIn;
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      if (push && !pop)      cnt <= cnt + 3'd1;
      else if (pop && !push) cnt <= cnt - 3'd1;
      if (push_req && !push)                      ovf <= 1'b1;
      else if (wr && off == 2'd1 && DataIn[2])    ovf <= 1'b0;
    end
  end

`ifdef IO_PORT_TIMER_EN
  logic [7:0] count;
  logic [7:0] reload;
  logic       en;
  logic       auto_rl;
  logic       exp_q;

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      count   <= 8'h00;
      reload  <= 8'h00;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      if (wr && off == 2'd3) {auto_rl, en} <= DataIn[1:0];
      if (wr && off == 2'd1 && DataIn[3]) exp_q <= 1'b0;
      if (wr && off == 2'd2) begin
        count  <= DataIn;
        reload <= DataIn;
      end else if (en && count > 8'd1) begin
        count <= count - 8'd1;
      end else if (en && count == 8'd1) begin
        // Later assignment lets expiry beat a coincident clear.
        exp_q <= 1'b1;
        count <= auto_rl ? reload : 8'h00;
      end
    end
  end

  assign exp_flag = exp_q;
`else
  assign exp_flag = 1'b0;
`endif

  assign irq = exp_flag;

  always_comb begin
    rdata = 8'h00;
    case (off)
      2'd0: rdata = tx_data;
      2'd1: rdata = {1'b0, cnt, exp_flag, ovf, full, empty};
`ifdef IO_PORT_TIMER_EN
      2'd2: rdata = count;
      2'd3: rdata = {6'b0, auto_rl, en};
`endif
      default: rdata = 8'h00;
    endcase
  end

  assign DataOut = SEL ? rdata : 8'h00;

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - directed self-checking bench for io_port
module tb_io_port;

  logic        CLK = 1'b0;
  logic        R;
  logic [15:0] Address;
  logic        WE;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  logic        SEL;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int total = 0;
  int bad   = 0;

  io_port dut (
    .CLK(CLK), .R(R), .Address(Address), .WE(WE), .DataIn(DataIn),
    .DataOut(DataOut), .SEL(SEL), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Called at a negedge; the write commits on the following rising edge.
  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    Address = a;
    DataIn  = d;
    WE      = 1'b1;
    @(negedge CLK);
    WE      = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [15:0] a, input logic [7:0] want);
    Address = a;
    #1;
    check(tag, DataOut, want);
  endtask

  task automatic fill4();
    bus_wr(16'hFFF0, 8'h11);
    bus_wr(16'hFFF0, 8'h22);
    bus_wr(16'hFFF0, 8'h33);
    bus_wr(16'hFFF0, 8'h44);
  endtask

  task automatic drain(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] seq [4];
    seq = '{b0, b1, b2, b3};
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check(tag, tx_data, seq[i]);
      @(negedge CLK);
    end
    #1;
    check({tag, "_empty"}, {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
  endtask

  initial begin
    R = 1'b1; WE = 1'b0; DataIn = 8'h00; Address = 16'h0000; tx_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_valid", {7'b0, tx_valid}, 8'h00);
    check("rst_txdata", tx_data, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    bus_rd("rst_status", 16'hFFF1, 8'h01);
    R = 1'b0;
    @(negedge CLK);

    for (int rep = 0; rep < 3; rep++) begin
      fill4();
      bus_rd("full_status", 16'hFFF1, 8'h42);
      bus_rd("head_read", 16'hFFF0, 8'h11);
      drain("order", 8'h11, 8'h22, 8'h33, 8'h44);
      @(negedge CLK);
    end

    fill4();
    bus_wr(16'hFFF0, 8'h55);
    bus_rd("ovf_status", 16'hFFF1, 8'h46);
    bus_wr(16'hFFF1, 8'h04);
    bus_rd("ovf_clear", 16'hFFF1, 8'h42);
    tx_ready = 1'b1;
    bus_wr(16'hFFF0, 8'h66);
    tx_ready = 1'b0;
    bus_rd("pushpop_status", 16'hFFF1, 8'h42);
    drain("pushpop", 8'h22, 8'h33, 8'h44, 8'h66);
    @(negedge CLK);

    bus_wr(16'hFFF4, 8'h77);
    bus_wr(16'hFFEF, 8'h03);
    Address = 16'hFFF4; #1;
    check("sel_hi", {7'b0, SEL}, 8'h00);
    check("dout_hi", DataOut, 8'h00);
    Address = 16'hFFEF; #1;
    check("sel_lo", {7'b0, SEL}, 8'h00);
    bus_rd("decode_status", 16'hFFF1, 8'h01);
    bus_rd("decode_tctrl", 16'hFFF3, 8'h00);
    @(negedge CLK);

`ifdef IO_PORT_TIMER_EN
    bus_wr(16'hFFF2, 8'h03);
    bus_rd("tmr_load", 16'hFFF2, 8'h03);
    bus_wr(16'hFFF3, 8'h01);
    bus_rd("tmr_c3", 16'hFFF2, 8'h03);
    @(negedge CLK);
    bus_rd("tmr_c2", 16'hFFF2, 8'h02);
    @(negedge CLK);
    bus_rd("tmr_c1", 16'hFFF2, 8'h01);
    check("tmr_irq_pre", {7'b0, irq}, 8'h00);
    @(negedge CLK);
    bus_rd("tmr_c0", 16'hFFF2, 8'h00);
    check("tmr_irq", {7'b0, irq}, 8'h01);
    bus_rd("tmr_status", 16'hFFF1, 8'h09);
    @(negedge CLK);
    bus_rd("tmr_hold", 16'hFFF2, 8'h00);
    bus_wr(16'hFFF1, 8'h08);
    #1;
    check("tmr_irq_clr", {7'b0, irq}, 8'h00);
    bus_wr(16'hFFF3, 8'h00);

    bus_wr(16'hFFF2, 8'h02);
    bus_wr(16'hFFF3, 8'h03);
    bus_rd("auto_c2", 16'hFFF2, 8'h02);
    @(negedge CLK);
    bus_rd("auto_c1", 16'hFFF2, 8'h01);
    check("auto_irq0", {7'b0, irq}, 8'h00);
    @(negedge CLK);
    bus_rd("auto_r2", 16'hFFF2, 8'h02);
    check("auto_irq1", {7'b0, irq}, 8'h01);
    bus_wr(16'hFFF1, 8'h08);
    bus_rd("auto_c1b", 16'hFFF2, 8'h01);
    check("auto_cleared", {7'b0, irq}, 8'h00);
    bus_wr(16'hFFF1, 8'h08);
    bus_rd("auto_r2b", 16'hFFF2, 8'h02);
    check("auto_set_wins", {7'b0, irq}, 8'h01);
    bus_wr(16'hFFF3, 8'h00);
    bus_wr(16'hFFF1, 8'h08);
    bus_wr(16'hFFF2, 8'h09);
    bus_wr(16'hFFF3, 8'h01);
`else
    bus_wr(16'hFFF2, 8'h05);
    bus_rd("off_timer", 16'hFFF2, 8'h00);
    bus_wr(16'hFFF3, 8'h03);
    bus_rd("off_tctrl", 16'hFFF3, 8'h00);
    bus_wr(16'hFFF1, 8'h08);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("off_irq", {7'b0, irq}, 8'h00);
    end
    bus_rd("off_status", 16'hFFF1, 8'h01);
`endif

    bus_wr(16'hFFF0, 8'hA1);
    bus_wr(16'hFFF0, 8'hA2);
    #1;
    check("pre_rst_valid", {7'b0, tx_valid}, 8'h01);
    #1;
    R = 1'b1;
    #1;
    check("mid_rst_valid", {7'b0, tx_valid}, 8'h00);
    check("mid_rst_txdata", tx_data, 8'h00);
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    bus_rd("mid_rst_status", 16'hFFF1, 8'h01);
    bus_rd("mid_rst_timer", 16'hFFF2, 8'h00);
    bus_rd("mid_rst_tctrl", 16'hFFF3, 8'h00);
    @(negedge CLK);
    R = 1'b0;
    @(negedge CLK);
    bus_rd("post_rst_status", 16'hFFF1, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
